// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared types and constants for the frame-level pattern scan controller
// and its serial 1-1-0-1-0 detector.
package pattern_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    D_IDLE,
    D_1,
    D_11,
    D_110,
    D_1101
  } det_e;

  localparam int FLUSH_CYCLES = 2;

  function automatic int pos_width(input int len_w, input int data_w);
    return len_w + $clog2(data_w);
  endfunction

endpackage

// File: rtl/pattern_detector.sv
// Serial Mealy detector for 1-1-0-1-0 with overlap.
// pattern_found is high in the cycle of the completing 0.
module pattern_detector
  import pattern_scan_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic stream_in,
  output logic pattern_found
);

  det_e st_q, st_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= D_IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d          = D_IDLE;
    pattern_found = 1'b0;
    unique case (st_q)
      D_IDLE: st_d = stream_in ? D_1    : D_IDLE;
      D_1:    st_d = stream_in ? D_11   : D_IDLE;
      D_11:   st_d = stream_in ? D_11   : D_110;
      D_110:  st_d = stream_in ? D_1101 : D_IDLE;
      D_1101: begin
        st_d          = stream_in ? D_11 : D_IDLE;
        pattern_found = !stream_in;
      end
      default: st_d = D_IDLE;
    endcase
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Frame controller: serializes words MSB-first into the detector,
// flushes it between frames, counts matches and records positions.
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 16,
  parameter int POS_W  = pos_width(LEN_W, DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              err_underrun,
  output logic              match_pulse,
  output logic [POS_W-1:0]  match_pos,
  output logic [CNT_W-1:0]  match_count,
  output logic              first_found,
  output logic [POS_W-1:0]  first_pos
);

  localparam int BW = $clog2(DATA_W);

  state_e            st_q, st_d;
  logic [1:0]        fl_q, fl_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  acc_q, acc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_v_q, hold_v_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ff_q, ff_d;
  logic [POS_W-1:0]  fpos_q, fpos_d;
  logic [POS_W-1:0]  mpos_q, mpos_d;
  logic              mp_q, mp_d;
  logic              err_q, err_d;
  logic              stream_in;
  logic              pattern_found;
  logic              take;

  pattern_detector u_det (
    .clk           (clk),
    .rst           (rst),
    .stream_in     (stream_in),
    .pattern_found (pattern_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= S_IDLE;
      fl_q     <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      bit_q    <= '0;
      pos_q    <= '0;
      sh_q     <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      cnt_q    <= '0;
      ff_q     <= 1'b0;
      fpos_q   <= '0;
      mpos_q   <= '0;
      mp_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      fl_q     <= fl_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      bit_q    <= bit_d;
      pos_q    <= pos_d;
      sh_q     <= sh_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      cnt_q    <= cnt_d;
      ff_q     <= ff_d;
      fpos_q   <= fpos_d;
      mpos_q   <= mpos_d;
      mp_q     <= mp_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    fl_d      = fl_q;
    len_d     = len_q;
    acc_d     = acc_q;
    bit_d     = bit_q;
    pos_d     = pos_q;
    sh_d      = sh_q;
    hold_d    = hold_q;
    hold_v_d  = hold_v_q;
    cnt_d     = cnt_q;
    ff_d      = ff_q;
    fpos_d    = fpos_q;
    mpos_d    = mpos_q;
    mp_d      = 1'b0;
    err_d     = err_q;
    stream_in = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    take      = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (start) begin
          st_d     = S_FLUSH;
          fl_d     = '0;
          len_d    = frame_len;
          acc_d    = '0;
          hold_v_d = 1'b0;
          cnt_d    = '0;
          ff_d     = 1'b0;
          fpos_d   = '0;
          err_d    = 1'b0;
        end
      end
      S_FLUSH: begin
        busy = 1'b1;
        fl_d = fl_q + 2'd1;
        if (fl_q == 2'(FLUSH_CYCLES - 1))
          st_d = (len_q == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          sh_d  = in_data;
          acc_d = acc_q + LEN_W'(1);
          bit_d = '0;
          pos_d = '0;
          st_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy      = 1'b1;
        stream_in = sh_q[DATA_W-1];
        sh_d      = sh_q << 1;
        bit_d     = bit_q + BW'(1);
        pos_d     = pos_q + POS_W'(1);
        in_ready  = !hold_v_q && (acc_q < len_q);
        take      = in_valid && in_ready;
        if (take) acc_d = acc_q + LEN_W'(1);
        // A word arriving on the last bit goes straight to the shifter.
        if (bit_q == BW'(DATA_W - 1)) begin
          if (hold_v_q) begin
            sh_d     = hold_q;
            hold_v_d = 1'b0;
          end else if (take) begin
            sh_d = in_data;
          end else begin
            st_d  = S_DONE;
            err_d = (acc_q != len_q);
          end
        end else if (take) begin
          hold_d   = in_data;
          hold_v_d = 1'b1;
        end
        if (pattern_found) begin
          cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          mp_d   = 1'b1;
          mpos_d = pos_q;
          if (!ff_q) begin
            ff_d   = 1'b1;
            fpos_d = pos_q;
          end
        end
      end
      S_DONE: begin
        done = 1'b1;
        st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  assign err_underrun = err_q;
  assign match_pulse  = mp_q;
  assign match_pos    = mpos_q;
  assign match_count  = cnt_q;
  assign first_found  = ff_q;
  assign first_pos    = fpos_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: directed and random frames checked
// against a string-match model with word-level timing arithmetic.
module tb_pattern_scan_ctrl;

  localparam int DW = 8;
  localparam int LW = 16;
  localparam int CW = 2;
  localparam int PW = LW + 3;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, busy, done, err_underrun;
  logic          match_pulse, first_found;
  logic [PW-1:0] match_pos, first_pos;
  logic [CW-1:0] match_count;

  pattern_scan_ctrl #(
    .DATA_W (DW),
    .LEN_W  (LW),
    .CNT_W  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .frame_len    (frame_len),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .busy         (busy),
    .done         (done),
    .err_underrun (err_underrun),
    .match_pulse  (match_pulse),
    .match_pos    (match_pos),
    .match_count  (match_count),
    .first_found  (first_found),
    .first_pos    (first_pos)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  logic [DW-1:0] wd [16];
  int            gp [16];
  logic [DW-1:0] tbl [6] = '{8'hD0, 8'hDA, 8'h1A, 8'h0D, 8'h6B, 8'hB4};

  task automatic clear_frame();
    foreach (gp[i]) begin
      gp[i] = 0;
      wd[i] = '0;
    end
  endtask

  // Called one time unit after a rising edge, with the DUT in IDLE.
  task automatic run_frame(input string nm, input int len);
    int t, l, a, o, e, nsent, under, edone;
    int taken, gdone, fin;
    bit got_it;
    int epos[$], ecyc[$], gpos[$], gcyc[$];
    logic b[$];
    logic [DW-1:0] w;
    logic [4:0] win;
    t = cyc;
    l = 0;
    nsent = 0;
    under = 0;
    if (len > 0) begin
      l = (gp[0] + 1 > 3) ? t + 1 + gp[0] : t + 3;
      a = l;
      nsent = 1;
      for (int k = 1; k < len; k++) begin
        o = a + 1 + gp[k];
        e = l + DW * (k - 1) + 1;
        if (e > o) o = e;
        if (o > l + DW * k) begin
          under = 1;
          break;
        end
        a = o;
        nsent++;
      end
    end
    edone = (len == 0) ? t + 3 : l + DW * nsent + 1;
    for (int k = 0; k < nsent; k++) begin
      w = wd[k];
      for (int j = DW - 1; j >= 0; j--) b.push_back(w[j]);
    end
    win = '0;
    for (int i = 0; i < b.size(); i++) begin
      win = {win[3:0], b[i]};
      if (i >= 4 && win == 5'b11010) begin
        epos.push_back(i);
        ecyc.push_back(l + i + 2);
      end
    end

    start = 1'b1;
    frame_len = LW'(len);
    @(posedge clk); #1;
    start = 1'b0;
    fin = 0;
    taken = 0;
    gdone = -1;
    fork
      begin
        for (int k = 0; k < len && fin == 0; k++) begin
          repeat (gp[k]) begin @(posedge clk); #1; end
          in_valid = 1'b1;
          in_data = wd[k];
          got_it = 1'b0;
          while (!got_it && fin == 0) begin
            @(negedge clk);
            got_it = in_ready;
            @(posedge clk); #1;
          end
          in_valid = 1'b0;
        end
      end
      begin
        for (int i = 0; i < 600 && fin == 0; i++) begin
          @(negedge clk);
          if (i == 0) begin
            chk({nm, " busy_flush"}, busy, 1);
            chk({nm, " rdy_flush"}, in_ready, 0);
          end
          if (in_valid && in_ready) taken++;
          if (match_pulse) begin
            gpos.push_back(int'(match_pos));
            gcyc.push_back(cyc);
          end
          if (done) begin
            fin = 1;
            gdone = cyc;
          end
        end
        fin = 1;
      end
    join

    chk({nm, " done_cyc"}, gdone, edone);
    chk({nm, " taken"}, taken, nsent);
    chk({nm, " underrun"}, err_underrun, under);
    chk({nm, " count"}, match_count,
        epos.size() > SAT ? SAT : epos.size());
    chk({nm, " first_found"}, first_found, epos.size() > 0);
    chk({nm, " first_pos"}, first_pos,
        epos.size() > 0 ? epos[0] : 0);
    chk({nm, " npulse"}, gpos.size(), epos.size());
    for (int i = 0; i < epos.size() && i < gpos.size(); i++) begin
      chk({nm, " pulse_pos"}, gpos[i], epos[i]);
      chk({nm, " pulse_cyc"}, gcyc[i], ecyc[i]);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " flags"},
        {busy, done, in_ready, err_underrun, match_pulse, first_found},
        0);
    chk({nm, " count"}, match_count, 0);
    chk({nm, " first_pos"}, first_pos, 0);
    chk({nm, " match_pos"}, match_pos, 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #3;
    chk_zero("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    clear_frame();
    wd[0] = 8'hD0;
    run_frame("d0", 1);

    clear_frame();
    wd[0] = 8'hDA;
    run_frame("da", 1);

    clear_frame();
    wd[0] = 8'h03;
    wd[1] = 8'h40;
    run_frame("span", 2);

    clear_frame();
    wd[0] = 8'hD0;
    gp[1] = 20;
    run_frame("under", 2);

    clear_frame();
    for (int i = 0; i < 5; i++) wd[i] = 8'hD0;
    run_frame("sat", 5);

    clear_frame();
    run_frame("empty", 0);

    // Abort a frame mid-shift after it has already scored a match.
    start = 1'b1;
    frame_len = LW'(3);
    in_valid = 1'b1;
    in_data = 8'hD0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("pre_rst count", match_count, 1);
    #2 rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    clear_frame();
    wd[0] = 8'hD0;
    run_frame("post_rst", 1);

    for (int f = 0; f < 14; f++) begin
      int len;
      clear_frame();
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        wd[k] = ($urandom_range(0, 2) == 0) ? DW'($urandom)
                                             : tbl[$urandom_range(0, 5)];
        gp[k] = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 16)
                                             : $urandom_range(0, 4);
      end
      run_frame($sformatf("rnd%0d", f), len);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule
